// File: rtl/pad_input_filter.sv
// pad_input_filter
//
// Per-pad input conditioning between the pad ring and the peripheral
// register file. Each pad is first brought into the clk_i domain by a
// two-flop synchroniser. It then passes through a counter-based glitch
// filter: a new level must hold for thresh_i+1 consecutive cycles before
// it reaches data_o.
//
// Optional feature macro: PAD_INPUT_FILTER_EDGE_DET_EN
//   defined   : rise_o / fall_o give one-cycle pulses on data_o edges
//   undefined : rise_o / fall_o are tied to 0 and no edge flops are built
//
// Parameters
//   NumPads  : number of independent pad channels
//   CntWidth : width of the stability counter and of thresh_i
//
// Ports
//   clk_i       : core clock
//   rst_ni      : asynchronous active-low reset
//   pad_in_i    : raw pad inputs, asynchronous to clk_i
//   filter_en_i : per-pad filter enable (0 = synchronise only)
//   thresh_i    : global stability threshold T, quasi-static
//   data_o      : synchronised, filtered pad value (registered)
//   rise_o      : one-cycle pulse on a 0->1 change of data_o
//   fall_o      : one-cycle pulse on a 1->0 change of data_o
module pad_input_filter #(
  parameter int unsigned NumPads  = 8,
  parameter int unsigned CntWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPads-1:0]  pad_in_i,
  input  logic [NumPads-1:0]  filter_en_i,
  input  logic [CntWidth-1:0] thresh_i,
  output logic [NumPads-1:0]  data_o,
  output logic [NumPads-1:0]  rise_o,
  output logic [NumPads-1:0]  fall_o
);

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [NumPads-1:0]               s1_q;
  logic [NumPads-1:0]               s2_q;
  logic [NumPads-1:0]               filt_q;
  logic [NumPads-1:0]               filt_d;
  logic [NumPads-1:0][CntWidth-1:0] cnt_q;
  logic [NumPads-1:0][CntWidth-1:0] cnt_d;

  // Synchroniser stage: s2_q is the only synchronised value used below.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pad_in_i;
      s2_q <= s2_q ^ (s2_q ^ s1_q);
    end
  end

  // Filter next state. Agreement between s2 and the filtered value has
  // priority over acceptance, so a level that reverts on the same cycle the
  // count reaches T is never taken. The >= compare lets a lowered threshold
  // accept immediately; the counter stays bounded by thresh_i and never wraps.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < int'(NumPads); i++) begin
      if (!filter_en_i[i]) begin
        filt_d[i] = s2_q[i];
      end else if (s2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= thresh_i) begin
        filt_d[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  // Filter state stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = filt_q;

`ifdef PAD_INPUT_FILTER_EDGE_DET_EN
  logic [NumPads-1:0] prev_q;

  // Edge detect stage: prev_q resets to the same value as filt_q, so leaving
  // reset never produces a pulse by itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
    end else begin
      prev_q <= filt_q;
    end
  end

  assign rise_o =  filt_q & ~prev_q;
  assign fall_o = ~filt_q &  prev_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

// File: tb/tb_pad_input_filter.sv
module tb_pad_input_filter;

  localparam int NP = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] pad_in = '0;
  logic [NP-1:0] fen = '0;
  logic [CW-1:0] thr = '0;
  logic [NP-1:0] data_o, rise_o, fall_o;

  int checks = 0;
  int failures = 0;

  pad_input_filter #(.NumPads(NP), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pad_in_i(pad_in), .filter_en_i(fen),
    .thresh_i(thr), .data_o(data_o), .rise_o(rise_o), .fall_o(fall_o)
  );

  always #5 clk = ~clk;

`ifdef PAD_INPUT_FILTER_EDGE_DET_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  task automatic check(input string name, input logic [NP-1:0] got, input logic [NP-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a pad follows its synchronised input once that input has
  // disagreed with the filtered value for more than T consecutive enabled
  // cycles. mark[i] holds the last cycle on which the pad was NOT in such a
  // disagreement run, so the run length is simply cyc - mark[i].
  longint        cyc = 0;
  longint        mark [NP];
  bit   [NP-1:0] m_s1 = '0, m_s2 = '0, m_filt = '0, m_hist = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0; m_hist = '0;
      for (int i = 0; i < NP; i++) mark[i] = cyc;
    end else begin
      cyc++;
      m_hist = m_filt;
      for (int i = 0; i < NP; i++) begin
        if (!fen[i] || m_s2[i] == m_filt[i]) begin
          m_filt[i] = m_s2[i];
          mark[i] = cyc;
        end else if (cyc - mark[i] >= longint'(thr) + 1) begin
          m_filt[i] = m_s2[i];
          mark[i] = cyc;
        end
      end
      m_s2 = m_s1;
      m_s1 = pad_in;
    end
  end

  // Continuous comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    check("model_data", data_o, m_filt);
    check("model_rise", rise_o, EDGE ? (m_filt & ~m_hist) : '0);
    check("model_fall", fall_o, EDGE ? (~m_filt & m_hist) : '0);
    checks++;
    if ((rise_o & fall_o) !== '0) begin
      failures++;
      $display("FAIL rise_and_fall got=%h exp=00", rise_o & fall_o);
    end
  end

  typedef struct {
    logic [NP-1:0] pad;
    logic [NP-1:0] en;
    logic [CW-1:0] t;
    int            hold;
    logic [NP-1:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hi_cnt, r_cnt, f_cnt;

  initial begin
    // Reset with all pads high, bypass.
    pad_in = '1; fen = '0; thr = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("reset_data", data_o, 8'h00);
      check("reset_rise", rise_o, 8'h00);
    end
    rst_n = 1'b1;
    tick(1); check("rel_e0", data_o, 8'h00);
    tick(1); check("rel_e1", data_o, 8'h00);
    tick(1); check("rel_e2", data_o, 8'hFF);
    check("rel_rise", rise_o, EDGE ? 8'hFF : 8'h00);
    tick(1); check("rel_rise_end", rise_o, 8'h00);

    // Table-driven vectors.
    vecs[0] = '{8'h00, 8'h00, 4'd0, 4, 8'h00};
    vecs[1] = '{8'hA5, 8'h00, 4'd0, 2, 8'h00};
    vecs[2] = '{8'hA5, 8'h00, 4'd0, 1, 8'hA5};
    vecs[3] = '{8'h5A, 8'hFF, 4'd2, 4, 8'hA5};
    vecs[4] = '{8'h5A, 8'hFF, 4'd2, 1, 8'h5A};
    vecs[5] = '{8'hFF, 8'hFF, 4'd0, 3, 8'hFF};
    vecs[6] = '{8'h00, 8'h0F, 4'd3, 3, 8'h0F};
    vecs[7] = '{8'h00, 8'h0F, 4'd3, 2, 8'h0F};
    vecs[8] = '{8'h00, 8'h0F, 4'd3, 1, 8'h00};
    for (int v = 0; v < 9; v++) begin
      pad_in = vecs[v].pad; fen = vecs[v].en; thr = vecs[v].t;
      tick(vecs[v].hold);
      check($sformatf("vec%0d", v), data_o, vecs[v].exp);
    end

    // Filtered latency: pad0, T=4.
    pad_in = '0; fen = '0; tick(4);
    fen = 8'h01; thr = 4'd4; pad_in = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("lat_data_%0d", k), data_o & 8'h01, (k >= 7) ? 8'h01 : 8'h00);
      check($sformatf("lat_rise_%0d", k), rise_o & 8'h01, (EDGE && k == 7) ? 8'h01 : 8'h00);
      check($sformatf("lat_fall_%0d", k), fall_o & 8'h01, 8'h00);
    end

    // Glitch reject: 4-cycle pulse rejected, 5-cycle pulse accepted.
    pad_in = 8'h00; tick(10);
    check("glitch_pre", data_o & 8'h01, 8'h00);
    hi_cnt = 0; r_cnt = 0; f_cnt = 0;
    pad_in = 8'h01; tick(4); pad_in = 8'h00;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      hi_cnt += int'(data_o[0]); r_cnt += int'(rise_o[0]);
    end
    check("glitch4_hi", 8'(hi_cnt), 8'd0);
    check("glitch4_rise", 8'(r_cnt), 8'd0);
    hi_cnt = 0; r_cnt = 0;
    pad_in = 8'h01; tick(5); pad_in = 8'h00;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      hi_cnt += int'(data_o[0]); r_cnt += int'(rise_o[0]); f_cnt += int'(fall_o[0]);
    end
    check("glitch5_hi", 8'(hi_cnt), 8'd5);
    check("glitch5_rise", 8'(r_cnt), EDGE ? 8'd1 : 8'd0);
    check("glitch5_fall", 8'(f_cnt), EDGE ? 8'd1 : 8'd0);

    // Threshold lowered mid-count: pad1, T=10 then 3 after 6 counts.
    fen = 8'h02; thr = 4'd10; pad_in = 8'h02;
    tick(8);
    check("thr_before", data_o & 8'h02, 8'h00);
    thr = 4'd3;
    tick(1);
    check("thr_accept", data_o & 8'h02, 8'h02);
    pad_in = 8'h00; tick(5);
    check("thr_fall_wait", data_o & 8'h02, 8'h02);
    tick(1);
    check("thr_fall", data_o & 8'h02, 8'h00);

    // Enable toggle: pad2, T=15.
    fen = 8'h04; thr = 4'd15; pad_in = 8'h04;
    tick(8);
    check("en_mid", data_o & 8'h04, 8'h00);
    fen = 8'h00;
    tick(1);
    check("en_bypass", data_o & 8'h04, 8'h04);
    fen = 8'h04; pad_in = 8'h00;
    tick(17);
    check("en_restart_hold", data_o & 8'h04, 8'h04);
    tick(1);
    check("en_restart_acc", data_o & 8'h04, 8'h00);

    // Randomised phase with one asynchronous mid-cycle reset.
    thr = 4'd3; fen = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++)
        if ($urandom_range(5) == 0) pad_in[i] = ~pad_in[i];
      if ($urandom_range(60) == 0) fen = 8'($urandom);
      if ($urandom_range(80) == 0) thr = 4'($urandom_range(6));
      if ($urandom_range(400) == 0) thr = 4'($urandom_range(15));
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #1 check("async_reset", data_o, 8'h00);
        @(negedge clk); rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
